// File: rtl/full_permutation_pipeline_pkg.sv
// Shared definitions for full_permutation_pipeline: result field offsets and the
// table of the six permutations of block-index bits (variables 4..6).
package full_permutation_pipeline_pkg;

  localparam int SUM_LSB   = 0;
  localparam int COUNT_LSB = 48;
  localparam int ECC_BIT   = 63;
  localparam int NUM_PERMS = 6;

  // Each entry is {sel2, sel1, sel0}: destination block bit k takes source block bit sel_k.
  localparam logic [5:0] PERM_TABLE [NUM_PERMS] = '{
    6'b10_01_00, 6'b10_00_01, 6'b01_10_00,
    6'b00_01_10, 6'b01_00_10, 6'b00_10_01
  };

  function automatic logic [2:0] permuteBlock(input logic [5:0] entry, input logic [2:0] blk);
    return {blk[entry[5:4]], blk[entry[3:2]], blk[entry[1:0]]};
  endfunction

endpackage

// File: rtl/full_permutation_pipeline_if.sv
// Record-in / result-out stream bundle for full_permutation_pipeline.
// master is the host/consumer side, slave is the pipeline side.
interface full_permutation_pipeline_if;

  logic        ivalid;
  logic        oready;
  logic        startNewTop;
  logic [63:0] botLower;
  logic [63:0] botUpper;
  logic        ovalid;
  logic        iready;
  logic [63:0] summedDataPcoeffCountOut;

  modport master (
    output ivalid, startNewTop, botLower, botUpper, iready,
    input  oready, ovalid, summedDataPcoeffCountOut
  );

  modport slave (
    input  ivalid, startNewTop, botLower, botUpper, iready,
    output oready, ovalid, summedDataPcoeffCountOut
  );

endinterface

// File: rtl/full_permutation_pipeline_permute_score.sv
// Combinational scorer: moves whole 16-bit blocks of bot by one block-index
// permutation, then reports containment in top and the count of uncovered top bits.
module permute_score
  import full_permutation_pipeline_pkg::*;
(
  input  logic [127:0] top,
  input  logic [127:0] bot,
  input  logic [2:0]   permIdx,
  output logic         valid,
  output logic [7:0]   term
);

  logic [5:0]   entry;
  logic [127:0] pbot;

  always_comb begin
    entry = PERM_TABLE[permIdx];
    pbot  = '0;
    for (int s = 0; s < 8; s++) begin
      pbot[permuteBlock(entry, 3'(s)) * 16 +: 16] = bot[s * 16 +: 16];
    end
  end

  assign valid = ~|(pbot & ~top);
  assign term  = 8'($countones(top & ~pbot));

endmodule

// File: rtl/full_permutation_pipeline.sv
// Three-stage bot-vs-top permutation scorer with top-period occupancy stats.
// Optional build macro PARITY_CHECK_EN adds an even-parity guard on the top register.
module full_permutation_pipeline
  import full_permutation_pipeline_pkg::*;
(
  input logic                         clock,
  input logic                         rst,
  full_permutation_pipeline_if.slave  bus
);

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic advance, accept, topLoad, eccErr;
  logic [31:0]  cycleCnt, botCnt;
  logic [127:0] topReg;

  assign advance    = !bus.ovalid || bus.iready;
  assign bus.oready = advance && !rst;
  assign accept     = bus.ivalid && bus.oready;
  assign topLoad    = accept && bus.startNewTop;

  always_ff @(posedge clock) begin
    if (rst) begin
      cycleCnt <= '0;
      botCnt   <= '0;
    end else if (topLoad) begin
      cycleCnt <= '0;
      botCnt   <= '0;
    end else begin
      cycleCnt <= satInc(cycleCnt);
      if (accept) botCnt <= satInc(botCnt);
    end
  end

`ifdef PARITY_CHECK_EN
  logic topParity;
  always_ff @(posedge clock) begin
    if (rst) begin
      topReg    <= '0;
      topParity <= 1'b0;
    end else if (topLoad) begin
      topReg    <= {bus.botUpper, bus.botLower};
      topParity <= ^{bus.botUpper, bus.botLower};
    end
  end
  assign eccErr = (^topReg) != topParity;
`else
  always_ff @(posedge clock) begin
    if (rst)          topReg <= '0;
    else if (topLoad) topReg <= {bus.botUpper, bus.botLower};
  end
  assign eccErr = 1'b0;
`endif

  logic         vld_p1, vld_p2;
  logic         isTop_p1, isTop_p2, ecc_p2;
  logic [127:0] bot_p1;
  logic [63:0]  stats_p1, stats_p2;
  logic [NUM_PERMS-1:0] permValid, permValid_p2;
  logic [7:0]   permTerm [NUM_PERMS];
  logic [7:0]   permTerm_p2 [NUM_PERMS];

  always_ff @(posedge clock) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
    end
  end

  // Stage 1: capture the record and the counter snapshot taken at acceptance
  always_ff @(posedge clock) begin
    if (advance) begin
      isTop_p1 <= bus.startNewTop;
      bot_p1   <= {bus.botUpper, bus.botLower};
      stats_p1 <= {botCnt, satInc(cycleCnt)};
    end
  end

  // Stage 2: six permutations scored in parallel against the current top
  for (genvar k = 0; k < NUM_PERMS; k++) begin : gPerm
    permute_score uScore (
      .top     (topReg),
      .bot     (bot_p1),
      .permIdx (3'(k)),
      .valid   (permValid[k]),
      .term    (permTerm[k])
    );
  end

  always_ff @(posedge clock) begin
    if (advance) begin
      permValid_p2 <= permValid;
      permTerm_p2  <= permTerm;
      isTop_p2     <= isTop_p1;
      stats_p2     <= stats_p1;
      ecc_p2       <= eccErr;
    end
  end

  // Stage 3: reduce to sum/count and form the result word
  logic [9:0]  sumAll;
  logic [2:0]  cntAll;
  logic [63:0] resultWord;

  always_comb begin
    sumAll = '0;
    cntAll = '0;
    for (int k = 0; k < NUM_PERMS; k++) begin
      if (permValid_p2[k]) sumAll = sumAll + {2'b00, permTerm_p2[k]};
      cntAll = cntAll + {2'b00, permValid_p2[k]};
    end
    resultWord = '0;
    if (isTop_p2) begin
      resultWord = stats_p2;
    end else begin
      resultWord[SUM_LSB +: 48]   = 48'(sumAll);
      resultWord[COUNT_LSB +: 13] = 13'(cntAll);
      resultWord[ECC_BIT]         = ecc_p2;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      bus.ovalid                   <= 1'b0;
      bus.summedDataPcoeffCountOut <= '0;
    end else if (advance) begin
      bus.ovalid <= vld_p2;
      if (vld_p2) bus.summedDataPcoeffCountOut <= resultWord;
    end
  end

endmodule

// File: tb/tb_full_permutation_pipeline.sv
// Bench for full_permutation_pipeline: directed vector table, counter/latency/stall/reset
// sequences, and randomized traffic scored by an enumerative reference model.
module tb_full_permutation_pipeline;

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  full_permutation_pipeline_if bus ();

  full_permutation_pipeline dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0]  expQ [$];
  logic [127:0] mTop;
  logic [31:0]  mCycle, mBot;

  typedef struct {
    logic [127:0] top;
    logic [127:0] bot;
    logic [63:0]  exp;
  } vec_t;
  vec_t vecs [7];

  function automatic logic [31:0] sat32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [63:0] mkRes(input int cnt, input int sum);
    return {3'b000, 13'(cnt), 48'(sum)};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Enumerate every ordering (a,b,c) of the three block-index variables
  function automatic logic [63:0] refScore(input logic [127:0] top, input logic [127:0] bot);
    int sum, cnt, s, d;
    int p [3];
    logic [127:0] pb;
    sum = 0;
    cnt = 0;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < 3; c++) begin
          if (a != b && b != c && a != c) begin
            p  = '{a, b, c};
            pb = '0;
            for (int i = 0; i < 128; i++) begin
              s = i / 16;
              d = ((s >> p[0]) & 1) | (((s >> p[1]) & 1) << 1) | (((s >> p[2]) & 1) << 2);
              pb[d * 16 + (i % 16)] = bot[i];
            end
            if ((pb & ~top) == '0) begin
              cnt++;
              sum += $countones(top & ~pb);
            end
          end
        end
    return mkRes(cnt, sum);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One clock: drive, resolve both handshakes on settled signals, update model, advance.
  task automatic tick(input logic v, input logic t, input logic [127:0] b, input logic r,
                      input logic rs, input bit useExp, input logic [63:0] exp);
    bit acc;
    bus.ivalid      = v;
    bus.startNewTop = t;
    bus.botLower    = b[63:0];
    bus.botUpper    = b[127:64];
    bus.iready      = r;
    rst             = rs;
    #1;
    acc = v && bus.oready;
    if (rs) begin
      check("oreadyInReset", 64'(bus.oready), 64'd0);
      expQ.delete();
      mTop   = '0;
      mCycle = '0;
      mBot   = '0;
    end else begin
      if (bus.ovalid && r) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpectedResult: got %h expected none", bus.summedDataPcoeffCountOut);
        end else begin
          check("result", bus.summedDataPcoeffCountOut, expQ.pop_front());
        end
      end
      if (acc) begin
        if (t) begin
          expQ.push_back(useExp ? exp : {mBot, sat32(mCycle)});
          mTop = b;
        end else begin
          expQ.push_back(useExp ? exp : refScore(mTop, b));
        end
      end
      if (acc && t) begin
        mCycle = '0;
        mBot   = '0;
      end else begin
        mCycle = sat32(mCycle);
        if (acc) mBot = sat32(mBot);
      end
    end
    @(negedge clock);
  endtask

  task automatic send(input logic t, input logic [127:0] b);
    tick(1'b1, t, b, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic sendExp(input logic t, input logic [127:0] b, input logic [63:0] exp);
    tick(1'b1, t, b, 1'b1, 1'b0, 1'b1, exp);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && expQ.size() > 0; i++) idle();
    check("drainEmpty", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] hold;
    logic [127:0] b;
    logic v, t, r;
    bus.ivalid = 1'b0; bus.startNewTop = 1'b0; bus.botLower = '0; bus.botUpper = '0;
    bus.iready = 1'b1; rst = 1'b1;
    mTop = '0; mCycle = '0; mBot = '0;

    vecs[0] = '{top: '1,                  bot: '0,                  exp: mkRes(6, 768)};
    vecs[1] = '{top: '1,                  bot: '1,                  exp: mkRes(6, 0)};
    vecs[2] = '{top: 128'hFFFF,           bot: 128'h1,              exp: mkRes(6, 90)};
    vecs[3] = '{top: 128'hFFFF,           bot: 128'h1_0000,         exp: mkRes(0, 0)};
    vecs[4] = '{top: 128'hFFFF_FFFF,      bot: 128'h1_0000,         exp: mkRes(2, 62)};
    vecs[5] = '{top: '0,                  bot: '0,                  exp: mkRes(6, 0)};
    vecs[6] = '{top: '0,                  bot: 128'h1,              exp: mkRes(0, 0)};

    @(negedge clock);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '1, 1'b1, 1'b1, 1'b0, '0);
    check("ovalidAfterReset", 64'(bus.ovalid), 64'd0);
    check("dataAfterReset", bus.summedDataPcoeffCountOut, 64'd0);
    idle();
    check("oreadyIdle", 64'(bus.oready), 64'd1);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      send(1'b1, vecs[i].top);
      sendExp(1'b0, vecs[i].bot, vecs[i].exp);
    end
    drain();

    // Top, four back-to-back bots, top
    send(1'b1, '1);
    for (int i = 0; i < 4; i++) send(1'b0, rnd128());
    sendExp(1'b1, '0, {32'd4, 32'd5});
    drain();

    // Three-cycle latency
    send(1'b0, 128'h5);
    check("latencyC1", 64'(bus.ovalid), 64'd0);
    idle();
    check("latencyC2", 64'(bus.ovalid), 64'd0);
    idle();
    check("latencyC3", 64'(bus.ovalid), 64'd1);
    drain();

    // Downstream stall for 10 cycles under a continuous stream
    send(1'b1, rnd128() | rnd128());
    for (int i = 0; i < 4; i++) send(1'b0, mTop & rnd128());
    bus.iready = 1'b0;
    #1;
    hold = bus.summedDataPcoeffCountOut;
    for (int i = 0; i < 10; i++) begin
      bus.iready = 1'b0;
      #1;
      check("stallOready", 64'(bus.oready), 64'd0);
      check("stallOvalid", 64'(bus.ovalid), 64'd1);
      check("stallData", bus.summedDataPcoeffCountOut, hold);
      tick(1'b1, 1'b0, rnd128(), 1'b0, 1'b0, 1'b0, '0);
    end
    for (int i = 0; i < 6; i++) send(1'b0, mTop & rnd128());
    drain();

    // Reset in the middle of a stream
    for (int i = 0; i < 3; i++) send(1'b0, rnd128());
    tick(1'b1, 1'b0, rnd128(), 1'b1, 1'b1, 1'b0, '0);
    check("ovalidAfterMidReset", 64'(bus.ovalid), 64'd0);
    idle();
    idle();
    idle();
    send(1'b0, 128'h3);
    send(1'b1, 128'hFF00_FF00);
    send(1'b0, 128'h0F00_0000);
    drain();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      v = ($urandom % 4) != 0;
      t = ($urandom % 8) == 0;
      r = ($urandom % 4) != 0;
      if (t)                    b = rnd128() | rnd128() | {8{16'($urandom % 2 ? 16'hFFFF : 16'h0)}};
      else if ($urandom % 2)    b = mTop & rnd128() & rnd128();
      else                      b = mTop & {112'h0, 16'($urandom)};
      tick(v, t, b, r, 1'b0, 1'b0, '0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_permutation_pipeline.md
# full_permutation_pipeline

Streaming datapath that scores 128-bit "bot" functions against a current 128-bit "top" under all six permutations of the final three variables. For each bot it emits the summed score and the count of permutations that pass. A `startNewTop` record loads a new top and emits occupancy statistics for the previous top period. The block sits between the host input stream and the result stream, using OpenCL-library-style handshakes.

## Interface
- No parameters.
- `clock` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `ivalid` in 1: input record valid.
- `oready` out 1: block can accept input.
- `startNewTop` in 1: record is a top, not a bot.
- `botLower` in 64: function bits [63:0].
- `botUpper` in 64: function bits [127:64].
- `ovalid` out 1: result valid.
- `iready` in 1: downstream accepts result.
- `summedDataPcoeffCountOut` out 64: result word.

## Operation
- An input is accepted when `ivalid && oready`. A result is consumed when `ovalid && iready`.
- Exactly one result is produced per accepted record, in input order.
- Function bit index i = {b[2:0], j[3:0]}: block b, 16 bits wide. A permutation of variables 4..6 permutes the three bits of b, moving whole 16-bit blocks. All 6 permutations are evaluated in parallel.
- **Bot record:**
  - pbot = permuted bot.
  - A permutation is valid iff (pbot & ~top) == 0.
  - term = popcount(top & ~pbot), range 0..128.
  - Result bits [47:0] = sum of terms over valid permutations, zero-extended.
  - Bits [60:48] = number of valid permutations (0..6).
  - Bits [62:61] = 0.
  - Bit 63 = ECC status (see Configuration).
- **Top record:**
  - The bot field becomes the new top. It applies to bots accepted after it, never to itself.
  - Result [63:32] = bots accepted since the previous top.
  - Result [31:0] = cycles since the previous top acceptance, counted per the rule below.
- **Counters** (both 32-bit, saturating, reset 0):
  - cycleCnt: on a top acceptance, snapshot cycleCnt+1, then clear to 0. Otherwise increment.
  - botCnt: on a top acceptance, snapshot, then clear. Otherwise increment on each bot acceptance.
- The top register resets to all zeros.

## Timing
- Three-stage pipeline.
  - Stage 1: register the input; top update.
  - Stage 2: permute, AND, per-permutation popcount.
  - Stage 3: sum and count into the output register.
- Latency with no stall: a record accepted at cycle n gives `ovalid` at n+3.
- Global stall: the pipeline advances iff `!ovalid || iready`. `oready` equals this advance term and is 0 while `rst`.
- While stalled, `ovalid` and data hold stable and nothing is lost or duplicated. Bubbles collapse when downstream is ready.
- Reset values: `ovalid`=0, output word 0, all stage valids 0, counters 0, top 0.
- Reset asserted mid-stream discards all in-flight records.
- A top and the bots behind it in the pipeline are ordered: each bot is scored against the top accepted most recently before it.

## Configuration
- `PARITY_CHECK_EN` defined:
  - The top register stores an even-parity bit computed on load.
  - Each bot result's bit 63 = 1 iff the recomputed parity of the stored top mismatches.
  - Top-record bit 63 is always 0.
- Undefined: bit 63 = 0 always, and no parity storage exists.

## Structure
- Shared package: result-field offsets (`SUM_LSB`=0, `COUNT_LSB`=48, `ECC_BIT`=63) and the 3-bit block permutation table (6 entries).
- One natural sub-module: `permute_score`. It is combinational, taking top, bot and a permutation index, and producing a valid flag and an 8-bit term. It is instantiated six times.

## Test plan
- Top all-ones, bot 0 -> sum 768, count 6.
- Top all-ones, bot all-ones -> sum 0, count 6.
- Top 0xFFFF (block 0 only), bot 0x0001 -> sum 90, count 6. Same top, bot bit 16 set -> sum 0, count 0.
- Top blocks 0–1 set (0xFFFFFFFF), bot bit 16 -> sum 62, count 2.
- Top, then 4 back-to-back bots, then top -> second top result [63:32]=4, [31:0]=5.
- `iready` low for 10 cycles with a continuous `ivalid` stream -> `oready` low, `ovalid`/data stable, all results delivered in order afterward. Reset mid-stream -> `ovalid`=0 next cycle.
